dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters:
  - Port A: the pipeline MEM stage.
  - Port B: the loader/debug port.
- Registers each accepted command and drives the memory for exactly one cycle.
- Captures read data and the memory error flag, then returns a one-cycle ack to the owning requester.
- Port A has fixed priority, with a starvation guard for port B; sits between the pipeline/loader and the data memory.

Parameters:
- STARVE_LIMIT, 4: consecutive A grants while B waits before B is forced to win; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  A request; held until a_ack.
- a_addr  in  32  A byte address.
- a_wdata  in  32  A store data.
- a_we  in  1  A write (1) / read (0).
- a_dsize  in  2  A size: 3 = word, 1 = half, 0 = byte, 2 = illegal.
- a_dsign  in  1  A signed load.
- a_ack  out  1  A completion pulse.
- a_rdata  out  32  A load data, valid with a_ack.
- a_err  out  1  A error, valid with a_ack.
- b_req, b_addr, b_wdata, b_we, b_dsize, b_dsign, b_ack, b_rdata, b_err: same as the A ports, for port B.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_dsize  out  2  memory size.
- mem_dsign  out  1  memory sign.
- mem_rdata  in  32  memory read data (combinational read).
- mem_error  in  1  memory error flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, DONE; reset state IDLE.
- Reset values:
  - All ack, err, rdata outputs 0.
  - Command registers 0.
  - Starvation counter 0.
  - owner = A.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner:
    - B wins if b_req && (!a_req || starve_cnt == STARVE_LIMIT).
    - Else A wins.
  - Latch the winner's addr/wdata/we/dsize/dsign and owner, then go to ACCESS.
- Starvation counter, updated at each IDLE decision:
  - A granted with b_req = 1: increment, saturating at STARVE_LIMIT.
  - B granted: clear.
  - b_req = 0: clear.
- ACCESS (exactly one cycle):
  - mem_* outputs driven from the command registers; mem_we = latched we.
  - The store commits at the closing posedge.
  - At that posedge, mem_rdata → owner rdata and mem_error → owner err, owner ack <= 1. Go to DONE.
- DONE (one cycle):
  - Owner ack = 1; the other port's ack stays 0. Go to IDLE.
  - Requester must deassert req during the ack cycle.
  - The arbiter does not sample req in DONE.
- Outside ACCESS: mem_we = 0, mem_addr / mem_wdata / mem_dsize / mem_dsign = 0. These are combinational from state, with no glitch onto mem_we.
- Latency: req sampled at edge N; ACCESS in cycle N..N+1; ack high in cycle N+1..N+2. Minimum 3 cycles per access, max throughput 1 access / 3 cycles.
- rdata/err hold their value until the port's next ack. Writes return rdata = whatever the memory presents during ACCESS (don't-care); err is valid for writes too.
- Illegal dsize (2) and misaligned accesses are passed through to the memory. Its error is reported on err, and the memory suppresses the write. No retry.
- Reset asserted mid-ACCESS: mem_we drops immediately, the store is not committed, no ack is produced, and the request is lost (requester re-issues after reset).
- Request fields changing while req is high before grant: the sampled value is the one at the grant edge.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_a_cnt [16]: completed A accesses, saturating at 16'hFFFF.
  - stat_b_cnt [16]: completed B accesses, saturating at 16'hFFFF.
  - stat_err_cnt [16]: accesses with err = 1, saturating at 16'hFFFF.
  - stat_force_b [16]: grants won by the starvation rule.
- Each stat counter increments at the DONE-entry edge; all reset to 0.
- When not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg: dsize encodings (DSIZE_WORD = 2'b11, DSIZE_HALF = 2'b01, DSIZE_BYTE = 2'b00, DSIZE_BAD = 2'b10), arbiter state encoding, port-id constants (PORT_A = 0, PORT_B = 1).
- One sub-module, dmem_arb_stats: the saturating counter bank, instantiated only under DMEM_ARB_STATS_EN. Arbitration FSM stays in dmem_arbiter.

Test Plan:
- A stores word 32'hDEADBEEF at 0x100, then A loads word 0x100 → mem_we high for exactly 1 cycle; a_ack 3 cycles after req; a_rdata = 32'hDEADBEEF, a_err = 0.
- a_req and b_req both held continuously, STARVE_LIMIT = 4 → grant order A, A, A, A, B, A, A, A, A, B…; b_ack never before the 5th grant.
- B loads a word at misaligned address 0x102 → b_err = 1 with b_ack, b_rdata = 0; a_ack stays 0.
- B signed-byte load of 0x80 at 0x7 → b_rdata = 32'hFFFFFF80; unsigned load → 32'h00000080.
- rst pulsed during ACCESS of A store of 32'h12345678 to 0x40 → mem_we falls at once, no a_ack, state IDLE; a later load from 0x40 does not return 32'h12345678.
- With DMEM_ARB_STATS_EN: 3 A accesses, 2 B accesses (1 erroring) → stat_a_cnt = 3, stat_b_cnt = 2, stat_err_cnt = 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// arbiter state encoding and requester port identifiers.
package dmem_pkg;

  localparam logic [1:0] DSIZE_WORD = 2'b11;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_BAD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating access/error/forced-grant counters for dmem_arbiter.
// Only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en_i,
  input  logic        owner_i,
  input  logic        err_i,
  input  logic        forced_i,
  output logic [15:0] stat_a_cnt_o,
  output logic [15:0] stat_b_cnt_o,
  output logic [15:0] stat_err_cnt_o,
  output logic [15:0] stat_force_b_o
);

  logic [15:0] aCnt_q, bCnt_q, errCnt_q, forceCnt_q;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aCnt_q     <= '0;
      bCnt_q     <= '0;
      errCnt_q   <= '0;
      forceCnt_q <= '0;
    end else if (count_en_i) begin
      if (owner_i == PORT_A) aCnt_q <= satInc(aCnt_q);
      else                   bCnt_q <= satInc(bCnt_q);
      if (err_i)    errCnt_q   <= satInc(errCnt_q);
      if (forced_i) forceCnt_q <= satInc(forceCnt_q);
    end
  end

  assign stat_a_cnt_o   = aCnt_q;
  assign stat_b_cnt_o   = bCnt_q;
  assign stat_err_cnt_o = errCnt_q;
  assign stat_force_b_o = forceCnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-ported data memory (A priority, B starvation guard).
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_we,
  input  logic [1:0]  a_dsize,
  input  logic        a_dsign,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_we,
  input  logic [1:0]  b_dsize,
  input  logic        b_dsign,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_dsize,
  output logic        mem_dsign,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic        busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_a_cnt,
  output logic [15:0] stat_b_cnt,
  output logic [15:0] stat_err_cnt,
  output logic [15:0] stat_force_b
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic              we_q, we_d, dsign_q, dsign_d;
  logic [1:0]        dsize_q, dsize_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              aAck_q, aAck_d, bAck_q, bAck_d;
  logic              aErr_q, aErr_d, bErr_q, bErr_d;
  logic [31:0]       aRdata_q, aRdata_d, bRdata_q, bRdata_d;
  logic              grantB;
`ifdef DMEM_ARB_STATS_EN
  logic              forced_q, forced_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= PORT_A;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      dsize_q  <= '0;
      dsign_q  <= 1'b0;
      starve_q <= '0;
      aAck_q   <= 1'b0;
      bAck_q   <= 1'b0;
      aErr_q   <= 1'b0;
      bErr_q   <= 1'b0;
      aRdata_q <= '0;
      bRdata_q <= '0;
`ifdef DMEM_ARB_STATS_EN
      forced_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      dsize_q  <= dsize_d;
      dsign_q  <= dsign_d;
      starve_q <= starve_d;
      aAck_q   <= aAck_d;
      bAck_q   <= bAck_d;
      aErr_q   <= aErr_d;
      bErr_q   <= bErr_d;
      aRdata_q <= aRdata_d;
      bRdata_q <= bRdata_d;
`ifdef DMEM_ARB_STATS_EN
      forced_q <= forced_d;
`endif
    end
  end

  assign grantB = b_req && (!a_req || (starve_q == LIMIT));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    dsize_d  = dsize_q;
    dsign_d  = dsign_q;
    starve_d = starve_q;
    aAck_d   = 1'b0;
    bAck_d   = 1'b0;
    aErr_d   = aErr_q;
    bErr_d   = bErr_q;
    aRdata_d = aRdata_q;
    bRdata_d = bRdata_q;
`ifdef DMEM_ARB_STATS_EN
    forced_d = forced_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Counter only climbs while A keeps winning against a waiting B.
        if (grantB || !b_req)      starve_d = '0;
        else if (starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
        if (a_req || b_req) begin
          state_d = ACCESS;
          owner_d = grantB ? PORT_B : PORT_A;
          addr_d  = grantB ? b_addr  : a_addr;
          wdata_d = grantB ? b_wdata : a_wdata;
          we_d    = grantB ? b_we    : a_we;
          dsize_d = grantB ? b_dsize : a_dsize;
          dsign_d = grantB ? b_dsign : a_dsign;
`ifdef DMEM_ARB_STATS_EN
          forced_d = grantB && a_req;
`endif
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (owner_q == PORT_A) begin
          aAck_d   = 1'b1;
          aRdata_d = mem_rdata;
          aErr_d   = mem_error;
        end else begin
          bAck_d   = 1'b1;
          bRdata_d = mem_rdata;
          bErr_d   = mem_error;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory bus is a pure decode of the registered state, so mem_we cannot glitch.
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign mem_dsize = (state_q == ACCESS) ? dsize_q : '0;
  assign mem_dsign = (state_q == ACCESS) && dsign_q;
  assign busy      = (state_q != IDLE);

  assign a_ack   = aAck_q;
  assign a_rdata = aRdata_q;
  assign a_err   = aErr_q;
  assign b_ack   = bAck_q;
  assign b_rdata = bRdata_q;
  assign b_err   = bErr_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats uStats (
    .clk            (clk),
    .rst            (rst),
    .count_en_i     (state_q == ACCESS),
    .owner_i        (owner_q),
    .err_i          (mem_error),
    .forced_i       (forced_q),
    .stat_a_cnt_o   (stat_a_cnt),
    .stat_b_cnt_o   (stat_b_cnt),
    .stat_err_cnt_o (stat_err_cnt),
    .stat_force_b_o (stat_force_b)
  );
`endif

endmodule
